bfly_pair_feeder: RTL and testbench
===================================

Name: bfly_pair_feeder

Overview:
Input-side feeder for the 8-lane radix-2 butterfly/twiddle stages of the 512-point FFT pipeline. It takes the upstream stream of N complex samples per beat and buffers DIST beats. It then emits aligned (upper, lower) operand pairs on din1/din2-style buses with a contiguous bf_en strobe, which is exactly what the butterfly stage consumes. It also marks the last pair of each block so the downstream stage can be re-armed.

Parameters:
N, 8, complex lanes per beat
IN_BIT, 13, signed width of each I/Q sample
DIST, 4, butterfly span in beats (pair distance = DIST*N samples); power of two, >=1
BLOCK_BEATS, 64, input beats per FFT block (512/N); multiple of 2*DIST

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
din_valid  in  1  input beat valid
din_i  in  [N] x IN_BIT signed  input real lanes
din_q  in  [N] x IN_BIT signed  input imag lanes
bf_en  out  1  pair valid, drives butterfly bfly_en
pair1_i  out  [N] x IN_BIT signed  upper operand real (earlier beat)
pair1_q  out  [N] x IN_BIT signed  upper operand imag
pair2_i  out  [N] x IN_BIT signed  lower operand real (current beat)
pair2_q  out  [N] x IN_BIT signed  lower operand imag
pair_last  out  1  high with bf_en on the last pair of a block
busy  out  1  high when a group or block is partially received

Behaviour:
- Reset: one clock, synchronous, active-high. All outputs go to 0 on the edge where rst=1: bf_en, pair_last, busy, all pair lanes.
  - State returns to FILL; beat counter and pair counter clear.
  - The buffer contents are don't-care.
  - A reset mid-block discards the partial group, and no pair is emitted for it.
- State machine: FILL and PAIR. A beat counter grp_cnt counts 0..DIST-1 and advances only on din_valid.
  - FILL: each valid beat is written to buf[grp_cnt]. On the DIST-th valid beat, move to PAIR and clear grp_cnt.
  - PAIR: on each valid beat, register the outputs:
    - pair1 = buf[grp_cnt], pair2 = din (lane for lane, no arithmetic, no width change);
    - bf_en = 1.
    - On the DIST-th valid beat, return to FILL.
- Latency: the output appears 1 cycle after the PAIR-phase input beat. The output registers hold their last value when bf_en=0; the bench checks data only when bf_en=1.
- Gaps: din_valid=0 freezes all counters and the state. bf_en=0 that cycle, with no data loss.
  - bf_en is therefore contiguous for exactly DIST cycles only if the input is gap-free during PAIR.
  - Upstream is required to present each PAIR group gap-free. The butterfly twiddle counter depends on this.
- Block tracking: pair_cnt counts emitted pairs 0..BLOCK_BEATS/2-1. pair_last=1 together with bf_en on count BLOCK_BEATS/2-1, after which pair_cnt wraps to 0.
- busy=1 whenever grp_cnt!=0, or state=PAIR, or pair_cnt!=0; otherwise 0. busy is registered and updates in the same cycle as the counters.
- Buffer: DIST entries of 2*N*IN_BIT bits. In FILL a write and a read never collide, because the buffer is read only in PAIR.
- Signed values pass through bit-exact, including -2^(IN_BIT-1).

Test Plan:
1. Gap-free ramp: beat b, lane l has i=b*8+l, q=-(b*8+l), for 8 beats.
   - Beats 4..7 give bf_en=1 for 4 consecutive cycles, each 1 cycle after its input beat.
   - Pair k shows pair1_i[l]=k*8+l and pair2_i[l]=(k+4)*8+l, with q equal to the negative.
2. Full block, 64 gap-free beats: exactly 32 bf_en cycles.
   - pair_last=1 only on the 32nd, and busy=0 afterwards.
   - A second block restarts the pairing with pair_cnt=0.
3. Gaps in FILL: valid pattern 1,0,1,1,0,0,1 followed by 4 valid beats.
   - The pairing is identical to scenario 1 and no bf_en is seen during FILL.
4. Gap in PAIR: din_valid drops for 2 cycles after 2 pairs.
   - bf_en drops for those 2 cycles, and the remaining 2 pairs resume with the correct buffered data, pair1 taken from buf[2] and buf[3].
5. Reset mid-operation: rst asserted for 1 cycle after 6 beats.
   - Next cycle: all outputs are 0.
   - The following 8 beats pair as in scenario 1, with no stale data.
6. Extremes: lanes set to -4096 and +4095.
   - Both values appear unchanged on pair1/pair2, and the sign is preserved.

Source files
------------

// File: rtl/bfly_pair_feeder.sv
// Input-side feeder for the radix-2 butterfly stages. It buffers DIST beats and then pairs each
// buffered beat with the matching beat DIST positions later, giving upper/lower operand pairs.
module bfly_pair_feeder #(
  parameter int unsigned N           = 8,
  parameter int unsigned IN_BIT      = 13,
  parameter int unsigned DIST        = 4,
  parameter int unsigned BLOCK_BEATS = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         din_valid,
  input  logic [N-1:0][IN_BIT-1:0]     din_i,
  input  logic [N-1:0][IN_BIT-1:0]     din_q,
  output logic                         bf_en,
  output logic [N-1:0][IN_BIT-1:0]     pair1_i,
  output logic [N-1:0][IN_BIT-1:0]     pair1_q,
  output logic [N-1:0][IN_BIT-1:0]     pair2_i,
  output logic [N-1:0][IN_BIT-1:0]     pair2_q,
  output logic                         pair_last,
  output logic                         busy
);

  localparam int unsigned Pairs = BLOCK_BEATS / 2;
  localparam int unsigned GW    = (DIST > 1) ? $clog2(DIST) : 1;
  localparam int unsigned PW    = (Pairs > 1) ? $clog2(Pairs) : 1;

  localparam logic [GW-1:0] GrpLast  = GW'(DIST - 1);
  localparam logic [PW-1:0] PairLast = PW'(Pairs - 1);

  typedef logic [N-1:0][IN_BIT-1:0] lanes_t;

  typedef enum logic [0:0] {StFill, StPair} state_e;

  state_e        state_q, state_d;
  logic [GW-1:0] grp_cnt_q, grp_cnt_d;
  logic [PW-1:0] pair_cnt_q, pair_cnt_d;
  logic          bf_en_q, bf_en_d;
  logic          pair_last_q, pair_last_d;
  logic          busy_q, busy_d;
  lanes_t        pair1_i_q, pair1_i_d;
  lanes_t        pair1_q_q, pair1_q_d;
  lanes_t        pair2_i_q, pair2_i_d;
  lanes_t        pair2_q_q, pair2_q_d;

  // Buffer contents are don't-care after reset, so no reset on this storage.
  lanes_t buf_i_q [DIST];
  lanes_t buf_q_q [DIST];

  always_comb begin
    state_d     = state_q;
    grp_cnt_d   = grp_cnt_q;
    pair_cnt_d  = pair_cnt_q;
    bf_en_d     = 1'b0;
    pair_last_d = 1'b0;
    pair1_i_d   = pair1_i_q;
    pair1_q_d   = pair1_q_q;
    pair2_i_d   = pair2_i_q;
    pair2_q_d   = pair2_q_q;

    if (din_valid) begin
      grp_cnt_d = (grp_cnt_q == GrpLast) ? '0 : grp_cnt_q + 1'b1;
      unique case (state_q)
        StFill: begin
          if (grp_cnt_q == GrpLast) state_d = StPair;
        end
        StPair: begin
          bf_en_d     = 1'b1;
          pair1_i_d   = buf_i_q[grp_cnt_q];
          pair1_q_d   = buf_q_q[grp_cnt_q];
          pair2_i_d   = din_i;
          pair2_q_d   = din_q;
          pair_last_d = (pair_cnt_q == PairLast);
          pair_cnt_d  = (pair_cnt_q == PairLast) ? '0 : pair_cnt_q + 1'b1;
          if (grp_cnt_q == GrpLast) state_d = StFill;
        end
        default: state_d = StFill;
      endcase
    end

    busy_d = (grp_cnt_d != '0) || (state_d == StPair) || (pair_cnt_d != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StFill;
      grp_cnt_q   <= '0;
      pair_cnt_q  <= '0;
      bf_en_q     <= 1'b0;
      pair_last_q <= 1'b0;
      busy_q      <= 1'b0;
      pair1_i_q   <= '0;
      pair1_q_q   <= '0;
      pair2_i_q   <= '0;
      pair2_q_q   <= '0;
    end else begin
      state_q     <= state_d;
      grp_cnt_q   <= grp_cnt_d;
      pair_cnt_q  <= pair_cnt_d;
      bf_en_q     <= bf_en_d;
      pair_last_q <= pair_last_d;
      busy_q      <= busy_d;
      pair1_i_q   <= pair1_i_d;
      pair1_q_q   <= pair1_q_d;
      pair2_i_q   <= pair2_i_d;
      pair2_q_q   <= pair2_q_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && din_valid && (state_q == StFill)) begin
      buf_i_q[grp_cnt_q] <= din_i;
      buf_q_q[grp_cnt_q] <= din_q;
    end
  end

  assign bf_en     = bf_en_q;
  assign pair_last = pair_last_q;
  assign busy      = busy_q;
  assign pair1_i   = pair1_i_q;
  assign pair1_q   = pair1_q_q;
  assign pair2_i   = pair2_i_q;
  assign pair2_q   = pair2_q_q;

endmodule

// File: tb/tb_bfly_pair_feeder.sv
// Directed bench for bfly_pair_feeder; expected pairs are derived from a beat history and queued
// when the lower beat is driven, then popped when bf_en shows up.
module tb_bfly_pair_feeder;

  localparam int unsigned N      = 8;
  localparam int unsigned IN_BIT = 13;
  localparam int unsigned DIST   = 4;
  localparam int unsigned BLOCK  = 64;

  typedef logic [N-1:0][IN_BIT-1:0] lanes_t;

  typedef struct {
    lanes_t i;
    lanes_t q;
  } beat_t;

  typedef struct {
    lanes_t p1i;
    lanes_t p1q;
    lanes_t p2i;
    lanes_t p2q;
    logic   last;
  } pair_t;

  logic   clk = 1'b0;
  logic   rst = 1'b0;
  logic   din_valid = 1'b0;
  lanes_t din_i = '0;
  lanes_t din_q = '0;
  logic   bf_en;
  lanes_t pair1_i, pair1_q, pair2_i, pair2_q;
  logic   pair_last;
  logic   busy;

  int checks   = 0;
  int failures = 0;

  beat_t hist[$];
  pair_t exp_q[$];
  int    nbeats = 0;
  int    npairs_seen = 0;
  int    nlast_seen = 0;

  bfly_pair_feeder #(
    .N          (N),
    .IN_BIT     (IN_BIT),
    .DIST       (DIST),
    .BLOCK_BEATS(BLOCK)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .din_valid(din_valid),
    .din_i    (din_i),
    .din_q    (din_q),
    .bf_en    (bf_en),
    .pair1_i  (pair1_i),
    .pair1_q  (pair1_q),
    .pair2_i  (pair2_i),
    .pair2_q  (pair2_q),
    .pair_last(pair_last),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  function automatic beat_t ramp(input int b);
    beat_t r;
    for (int l = 0; l < int'(N); l++) begin
      r.i[l] = IN_BIT'(b * 8 + l);
      r.q[l] = IN_BIT'(-(b * 8 + l));
    end
    return r;
  endfunction

  function automatic beat_t extreme(input int b);
    beat_t r;
    for (int l = 0; l < int'(N); l++) begin
      r.i[l] = (((l + b) % 2) == 0) ? IN_BIT'(-4096) : IN_BIT'(4095);
      r.q[l] = (((l + b) % 2) == 0) ? IN_BIT'(4095) : IN_BIT'(-4096);
    end
    return r;
  endfunction

  task automatic step(input bit v, input beat_t bt);
    bit    exp_en;
    pair_t e, got;
    exp_en = 1'b0;
    din_valid = v;
    din_i = bt.i;
    din_q = bt.q;
    if (v) begin
      if ((nbeats % (2 * DIST)) >= DIST) begin
        e.p1i  = hist[nbeats - DIST].i;
        e.p1q  = hist[nbeats - DIST].q;
        e.p2i  = bt.i;
        e.p2q  = bt.q;
        e.last = ((nbeats % BLOCK) == BLOCK - 1);
        exp_q.push_back(e);
        exp_en = 1'b1;
      end
      hist.push_back(bt);
      nbeats++;
    end
    @(posedge clk);
    #1;
    din_valid = 1'b0;
    checks++;
    assert (bf_en === exp_en) else begin
      failures++;
      $error("FAIL bf_en beat=%0d got=%b exp=%b", nbeats, bf_en, exp_en);
    end
    if (bf_en === 1'b1) begin
      npairs_seen++;
      if (pair_last === 1'b1) nlast_seen++;
      checks++;
      assert (exp_q.size() != 0) else begin
        failures++;
        $error("FAIL unexpected_pair got=1 exp=0");
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        got.p1i = pair1_i; got.p1q = pair1_q; got.p2i = pair2_i; got.p2q = pair2_q;
        checks++;
        assert ({got.p1i, got.p1q} === {e.p1i, e.p1q}) else begin
          failures++;
          $error("FAIL pair1 got=%h/%h exp=%h/%h", got.p1i, got.p1q, e.p1i, e.p1q);
        end
        checks++;
        assert ({got.p2i, got.p2q} === {e.p2i, e.p2q}) else begin
          failures++;
          $error("FAIL pair2 got=%h/%h exp=%h/%h", got.p2i, got.p2q, e.p2i, e.p2q);
        end
        checks++;
        assert (pair_last === e.last) else begin
          failures++;
          $error("FAIL pair_last got=%b exp=%b", pair_last, e.last);
        end
      end
    end else begin
      checks++;
      assert (pair_last === 1'b0) else begin
        failures++;
        $error("FAIL pair_last_idle got=%b exp=0", pair_last);
      end
    end
    checks++;
    assert (busy === ((nbeats % BLOCK) != 0)) else begin
      failures++;
      $error("FAIL busy got=%b exp=%b", busy, ((nbeats % BLOCK) != 0));
    end
  endtask

  task automatic do_reset();
    beat_t z;
    z.i = '0;
    z.q = '0;
    rst = 1'b1;
    din_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    hist.delete();
    exp_q.delete();
    nbeats = 0;
    checks++;
    assert ({bf_en, pair_last, busy} === 3'b000) else begin
      failures++;
      $error("FAIL reset_ctl got=%b exp=000", {bf_en, pair_last, busy});
    end
    checks++;
    assert ({pair1_i, pair1_q, pair2_i, pair2_q} === '0) else begin
      failures++;
      $error("FAIL reset_data got=%h exp=0", {pair1_i, pair1_q, pair2_i, pair2_q});
    end
    // An idle cycle straight after reset must stay quiet.
    step(1'b0, z);
  endtask

  task automatic check_drained(input string tag);
    checks++;
    assert (exp_q.size() == 0) else begin
      failures++;
      $error("FAIL drained_%s got=%0d exp=0", tag, exp_q.size());
    end
  endtask

  initial begin
    beat_t z;
    z.i = '0;
    z.q = '0;
    #2;
    do_reset();

    // 1: gap-free ramp
    for (int b = 0; b < 8; b++) step(1'b1, ramp(b));
    step(1'b0, z);
    check_drained("ramp");

    // 2: two full blocks, counting bf_en and pair_last
    do_reset();
    npairs_seen = 0;
    nlast_seen = 0;
    for (int b = 0; b < int'(BLOCK); b++) step(1'b1, ramp(b));
    step(1'b0, z);
    checks++;
    assert (npairs_seen == 32 && nlast_seen == 1) else begin
      failures++;
      $error("FAIL block_count got=%0d/%0d exp=32/1", npairs_seen, nlast_seen);
    end
    for (int b = 0; b < int'(BLOCK); b++) step(1'b1, ramp(b + 3));
    step(1'b0, z);
    checks++;
    assert (npairs_seen == 64 && nlast_seen == 2) else begin
      failures++;
      $error("FAIL block2_count got=%0d/%0d exp=64/2", npairs_seen, nlast_seen);
    end
    check_drained("block");

    // 3: gaps during FILL
    do_reset();
    step(1'b1, ramp(0));
    step(1'b0, ramp(9));
    step(1'b1, ramp(1));
    step(1'b1, ramp(2));
    step(1'b0, ramp(9));
    step(1'b0, ramp(9));
    step(1'b1, ramp(3));
    for (int b = 4; b < 8; b++) step(1'b1, ramp(b));
    step(1'b0, z);
    check_drained("fill_gap");

    // 4: gap during PAIR after two pairs
    do_reset();
    for (int b = 0; b < 6; b++) step(1'b1, ramp(b));
    step(1'b0, ramp(20));
    step(1'b0, ramp(21));
    step(1'b1, ramp(6));
    step(1'b1, ramp(7));
    step(1'b0, z);
    check_drained("pair_gap");

    // 5: reset mid-operation, then a clean pass with fresh data
    do_reset();
    for (int b = 0; b < 6; b++) step(1'b1, ramp(b + 40));
    do_reset();
    for (int b = 0; b < 8; b++) step(1'b1, ramp(b));
    step(1'b0, z);
    check_drained("mid_reset");

    // 6: full-scale signed extremes
    do_reset();
    for (int b = 0; b < 8; b++) step(1'b1, extreme(b));
    step(1'b0, z);
    check_drained("extreme");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
